spi_master: RTL and testbench



---
 rtl/spi_master_pkg.sv | 29 ++
 rtl/spi_master_if.sv | 26 ++
 rtl/spi_sck_gen.sv | 53 +++++
 rtl/spi_master.sv | 121 ++++++++++++
 tb/tb_spi_master.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_master_pkg.sv
// Shared types and sizing for the SPI master: FSM state encoding, byte limits
// and the width of the per-transaction bit counter.
package spi_master_pkg;

  localparam int BYTE_W       = 8;
  localparam int TX_MAX_BYTES = 2;
  localparam int RX_MAX_BYTES = 3;
  localparam int TX_W         = BYTE_W * TX_MAX_BYTES;
  localparam int OUT_W        = 32;
  localparam int CNT_W        = $clog2(BYTE_W * (TX_MAX_BYTES + RX_MAX_BYTES) + 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    TX,
    RX,
    DONE
  } state_e;

  // A transmit count of 3 is treated as the maximum of 2 bytes.
  function automatic logic [1:0] clamp_tx(input logic [1:0] n);
    return (n == 2'd3) ? 2'd2 : n;
  endfunction

  function automatic logic [CNT_W-1:0] bits_of(input logic [1:0] n);
    return CNT_W'({n, 3'b000});
  endfunction

endpackage

// File: rtl/spi_master_if.sv
// Sequencer handshake plus SPI pins for the temperature-sensor master.
// The master modport is the controller side; slave is the sequencer/sensor side.
interface spi_master_if;

  logic                              sck_out;
  logic                              mosi;
  logic                              miso;
  logic                              cs;
  logic [1:0]                        in_bytes_count;
  logic [1:0]                        out_bytes_count;
  logic [spi_master_pkg::TX_W-1:0]   in_bytes;
  logic [spi_master_pkg::OUT_W-1:0]  out_bytes;
  logic                              start_trans;
  logic                              trans_done;

  modport master (
    input  miso, in_bytes_count, out_bytes_count, in_bytes, start_trans,
    output sck_out, mosi, cs, out_bytes, trans_done
  );

  modport slave (
    output miso, in_bytes_count, out_bytes_count, in_bytes, start_trans,
    input  sck_out, mosi, cs, out_bytes, trans_done
  );

endinterface

// File: rtl/spi_sck_gen.sv
// SCK divider: SCK_DIV cycles per half period, idle low while disabled, with
// one-cycle strobes at the end of each low half (tick), on rise and on fall.
module spi_sck_gen #(
  parameter int SCK_DIV = 1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic en_i,
  input  logic last_i,
  output logic sck_o,
  output logic rise_o,
  output logic fall_o,
  output logic tick_o
);

  localparam int            CW = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(SCK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sck_q, sck_d;
  logic          tc;

  assign tc     = (cnt_q == TC);
  assign tick_o = en_i & tc & ~sck_q;
  // Once the final cell has been started, its low half ends without a new rise.
  assign rise_o = tick_o & ~last_i;
  assign fall_o = en_i & tc & sck_q;
  assign sck_o  = sck_q;

  always_comb begin
    cnt_d = cnt_q;
    sck_d = sck_q;
    if (!en_i) begin
      cnt_d = '0;
      sck_d = 1'b0;
    end else begin
      cnt_d = tc ? '0 : cnt_q + CW'(1);
      if (rise_o)      sck_d = 1'b1;
      else if (fall_o) sck_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master: up to 2 bytes out on MOSI, then up to 3 bytes in from MISO.
// Define SPI_LSB_FIRST_EN for LSB-first transfers in both directions.
module spi_master
  import spi_master_pkg::*;
#(
  parameter int SCK_DIV = 1
) (
  input  logic          sck_in,
  input  logic          rst_n,
  spi_master_if.master  bus
);

  state_e             state_q;
  logic               cs_q, mosi_q, done_q;
  logic [OUT_W-1:0]   out_q;
  logic [TX_W-1:0]    tx_sr_q;
  logic [CNT_W-1:0]   rem_q, rx_bits_q;

  logic               sck, rise, fall, tick, sck_en, last, tx_more, first_bit;
  logic [1:0]         tx_n;
  logic [CNT_W-1:0]   tx_bits_n, rx_bits_n;
  logic [TX_W-1:0]    tx_load, tx_shift;
  logic               tx_next_bit;
  logic [OUT_W-1:0]   rx_shift;

  assign tx_n      = clamp_tx(bus.out_bytes_count);
  assign tx_bits_n = bits_of(tx_n);
  assign rx_bits_n = bits_of(bus.in_bytes_count);
  assign sck_en    = (state_q == SETUP) || (state_q == TX) || (state_q == RX);
  assign last      = (rem_q == '0);
  // rem_q counts cells not yet started; anything beyond the RX cells is still TX.
  assign tx_more   = (rem_q > rx_bits_q);

`ifdef SPI_LSB_FIRST_EN
  assign tx_load     = (tx_n == 2'd1) ? {8'h00, bus.in_bytes[7:0]} : bus.in_bytes;
  assign first_bit   = (tx_n != 2'd0) & tx_load[0];
  assign tx_shift    = tx_sr_q >> 1;
  assign tx_next_bit = tx_sr_q[1];
  assign rx_shift    = (out_q >> 1) | (OUT_W'(bus.miso) << (rx_bits_q - CNT_W'(1)));
`else
  assign tx_load     = (tx_n == 2'd1) ? {bus.in_bytes[7:0], 8'h00} : bus.in_bytes;
  assign first_bit   = (tx_n != 2'd0) & tx_load[TX_W-1];
  assign tx_shift    = tx_sr_q << 1;
  assign tx_next_bit = tx_sr_q[TX_W-2];
  assign rx_shift    = {out_q[OUT_W-2:0], bus.miso};
`endif

  spi_sck_gen #(.SCK_DIV(SCK_DIV)) u_sck_gen (
    .clk_i   (sck_in),
    .rst_n_i (rst_n),
    .en_i    (sck_en),
    .last_i  (last),
    .sck_o   (sck),
    .rise_o  (rise),
    .fall_o  (fall),
    .tick_o  (tick)
  );

  always_ff @(posedge sck_in) begin
    if (state_q == IDLE && bus.start_trans) tx_sr_q <= tx_load;
    else if (fall && state_q == TX && tx_more) tx_sr_q <= tx_shift;
  end

  always_ff @(posedge sck_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cs_q      <= 1'b1;
      mosi_q    <= 1'b0;
      done_q    <= 1'b0;
      out_q     <= '0;
      rem_q     <= '0;
      rx_bits_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (bus.start_trans) begin
          rem_q     <= tx_bits_n + rx_bits_n;
          rx_bits_q <= rx_bits_n;
          out_q     <= '0;
          if (tx_n == 2'd0 && bus.in_bytes_count == 2'd0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= SETUP;
            cs_q    <= 1'b0;
            mosi_q  <= first_bit;
          end
        end
        SETUP, TX, RX: begin
          if (rise) begin
            rem_q <= rem_q - CNT_W'(1);
            if (tx_more) begin
              state_q <= TX;
            end else begin
              state_q <= RX;
              out_q   <= rx_shift;
            end
          end else if (tick) begin
            state_q <= DONE;
            cs_q    <= 1'b1;
            done_q  <= 1'b1;
            mosi_q  <= 1'b0;
          end else if (fall && state_q == TX) begin
            mosi_q <= tx_more ? tx_next_bit : 1'b0;
          end
        end
        DONE: if (!bus.start_trans) begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.sck_out    = sck;
  assign bus.mosi       = mosi_q;
  assign bus.cs         = cs_q;
  assign bus.out_bytes  = out_q;
  assign bus.trans_done = done_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: one instance at SCK_DIV=1, one at SCK_DIV=3,
// with a behavioural SPI slave and edge/cycle monitors.
module tb_spi_master;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  spi_master_if bus0 ();
  spi_master_if bus1 ();

  spi_master #(.SCK_DIV(1)) dut0 (.sck_in(clk), .rst_n(rst_n), .bus(bus0));
  spi_master #(.SCK_DIV(3)) dut1 (.sck_in(clk), .rst_n(rst_n), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] sck_w, cs_w, mosi_w;
  assign sck_w  = {bus1.sck_out, bus1.sck_out & 1'b0} | {1'b0, bus0.sck_out};
  assign cs_w   = {bus1.cs, bus0.cs};
  assign mosi_w = {bus1.mosi, bus0.mosi};

  int          rise_cnt[2]   = '{0, 0};
  int          cs_low_cyc[2] = '{0, 0};
  int          cs_fall[2]    = '{0, 0};
  int          hi_run[2]     = '{0, 0};
  int          lo_run[2]     = '{0, 0};
  int          hi_min[2]     = '{999, 999};
  int          hi_max[2]     = '{0, 0};
  int          lo_min[2]     = '{999, 999};
  int          lo_max[2]     = '{0, 0};
  logic [39:0] mosi_cap[2]   = '{40'd0, 40'd0};
  logic [1:0]  prev_sck      = 2'b00;
  logic [1:0]  prev_cs       = 2'b11;

  // Slave model: presents the bit for the next SCK rise, MSB first.
  int          m_base[2] = '{0, 0};
  int          m_tx[2]   = '{0, 0};
  int          m_rx[2]   = '{0, 0};
  logic [23:0] m_word[2] = '{24'd0, 24'd0};

  function automatic logic miso_bit(input int rc, input int base, input int tx,
                                    input int rx, input logic [23:0] w);
    int          idx;
    logic [23:0] t;
    idx = rc - base - 8 * tx;
    if (idx < 0 || idx >= 8 * rx) return 1'b0;
    t = w >> (8 * rx - 1 - idx);
    return t[0];
  endfunction

  assign bus0.miso = miso_bit(rise_cnt[0], m_base[0], m_tx[0], m_rx[0], m_word[0]);
  assign bus1.miso = miso_bit(rise_cnt[1], m_base[1], m_tx[1], m_rx[1], m_word[1]);

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      prev_sck[i] <= sck_w[i];
      prev_cs[i]  <= cs_w[i];
      if (sck_w[i] && !prev_sck[i]) begin
        rise_cnt[i] <= rise_cnt[i] + 1;
        mosi_cap[i] <= {mosi_cap[i][38:0], mosi_w[i]};
      end
      if (!cs_w[i]) cs_low_cyc[i] <= cs_low_cyc[i] + 1;
      if (!cs_w[i] && prev_cs[i]) cs_fall[i] <= cs_fall[i] + 1;
      if (!cs_w[i]) begin
        if (sck_w[i] && !prev_sck[i]) begin
          if (lo_run[i] < lo_min[i]) lo_min[i] <= lo_run[i];
          if (lo_run[i] > lo_max[i]) lo_max[i] <= lo_run[i];
          hi_run[i] <= 1;
        end else if (!sck_w[i] && prev_sck[i]) begin
          if (hi_run[i] < hi_min[i]) hi_min[i] <= hi_run[i];
          if (hi_run[i] > hi_max[i]) hi_max[i] <= hi_run[i];
          lo_run[i] <= 1;
        end else if (sck_w[i]) begin
          hi_run[i] <= hi_run[i] + 1;
        end else begin
          lo_run[i] <= lo_run[i] + 1;
        end
      end else begin
        hi_run[i] <= 0;
        lo_run[i] <= 0;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wait_done(input int sel, input int limit, input string tag);
    int n;
    n = 0;
    while (((sel == 0) ? bus0.trans_done : bus1.trans_done) !== 1'b1 && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq({tag, " trans_done"}, 32'((sel == 0) ? bus0.trans_done : bus1.trans_done), 32'd1);
  endtask

  int rb, cb, fb;

  task automatic go0(input logic [1:0] txc, input logic [1:0] rxc, input logic [15:0] data,
                     input int mtx, input int mrx, input logic [23:0] word);
    m_base[0] = rise_cnt[0];
    m_tx[0]   = mtx;
    m_rx[0]   = mrx;
    m_word[0] = word;
    rb = rise_cnt[0];
    cb = cs_low_cyc[0];
    fb = cs_fall[0];
    bus0.out_bytes_count = txc;
    bus0.in_bytes_count  = rxc;
    bus0.in_bytes        = data;
    bus0.start_trans     = 1'b1;
  endtask

  task automatic drop0();
    bus0.start_trans = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus0.start_trans = 1'b0; bus0.out_bytes_count = 2'd0; bus0.in_bytes_count = 2'd0; bus0.in_bytes = 16'd0;
    bus1.start_trans = 1'b0; bus1.out_bytes_count = 2'd0; bus1.in_bytes_count = 2'd0; bus1.in_bytes = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst cs",         32'(bus0.cs),         32'd1);
    check_eq("rst sck_out",    32'(bus0.sck_out),    32'd0);
    check_eq("rst mosi",       32'(bus0.mosi),       32'd0);
    check_eq("rst trans_done", 32'(bus0.trans_done), 32'd0);
    check_eq("rst out_bytes",  bus0.out_bytes,       32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Write only: 0xBEEF, 16 cells, cs low for 1 setup + 32 cycles
    go0(2'd2, 2'd0, 16'hBEEF, 2, 0, 24'd0);
    wait_done(0, 200, "wr");
    check_eq("wr sck rises",    32'(rise_cnt[0] - rb),      32'd16);
    check_eq("wr mosi bits",    32'(mosi_cap[0][15:0]),     32'h0000BEEF);
    check_eq("wr cs low cycles", 32'(cs_low_cyc[0] - cb),   32'd33);
    check_eq("wr out_bytes",    bus0.out_bytes,             32'd0);
    check_eq("wr cs",           32'(bus0.cs),               32'd1);
    repeat (10) @(posedge clk);
    #1;
    check_eq("hold cs assertions", 32'(cs_fall[0] - fb),   32'd1);
    check_eq("hold trans_done",    32'(bus0.trans_done),   32'd1);
    drop0();
    check_eq("drop trans_done",    32'(bus0.trans_done),   32'd0);

    // Write + read: slave returns 0xA5C3
    go0(2'd2, 2'd2, 16'hBEEF, 2, 2, 24'h00A5C3);
    wait_done(0, 300, "wrrd");
    check_eq("wrrd sck rises",  32'(rise_cnt[0] - rb),      32'd32);
    check_eq("wrrd mosi tx",    32'(mosi_cap[0][31:16]),    32'h0000BEEF);
    check_eq("wrrd mosi rx",    32'(mosi_cap[0][15:0]),     32'd0);
    check_eq("wrrd out_bytes",  bus0.out_bytes,             32'h0000A5C3);
    check_eq("wrrd cs",         32'(bus0.cs),               32'd1);
    drop0();

    // Transmit count 3 behaves as 2; one read byte 0x5A
    go0(2'd3, 2'd1, 16'hBEEF, 2, 1, 24'h00005A);
    wait_done(0, 300, "clamp");
    check_eq("clamp sck rises", 32'(rise_cnt[0] - rb),      32'd24);
    check_eq("clamp mosi tx",   32'(mosi_cap[0][23:8]),     32'h0000BEEF);
    check_eq("clamp out_bytes", bus0.out_bytes,             32'h0000005A);
    check_eq("clamp cs low cycles", 32'(cs_low_cyc[0] - cb), 32'd49);
    drop0();

    // Zero length: no chip select, no SCK, done right away, out_bytes cleared
    go0(2'd0, 2'd0, 16'h1234, 0, 0, 24'd0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check_eq("zero trans_done",   32'(bus0.trans_done),   32'd1);
    check_eq("zero out_bytes",    bus0.out_bytes,         32'd0);
    check_eq("zero sck rises",    32'(rise_cnt[0] - rb),  32'd0);
    check_eq("zero cs assertions", 32'(cs_fall[0] - fb),  32'd0);
    check_eq("zero cs",           32'(bus0.cs),           32'd1);
    drop0();

    // Reset during a write, after 5 SCK rises
    go0(2'd2, 2'd0, 16'hBEEF, 2, 0, 24'd0);
    for (int n = 0; n < 100 && (rise_cnt[0] - rb) < 5; n++) begin
      @(posedge clk);
      #1;
    end
    check_eq("abort rises before reset", 32'(rise_cnt[0] - rb), 32'd5);
    rst_n = 1'b0;
    bus0.start_trans = 1'b0;
    #1;
    check_eq("abort cs",         32'(bus0.cs),         32'd1);
    check_eq("abort sck_out",    32'(bus0.sck_out),    32'd0);
    check_eq("abort mosi",       32'(bus0.mosi),       32'd0);
    check_eq("abort trans_done", 32'(bus0.trans_done), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    go0(2'd1, 2'd0, 16'h00A5, 1, 0, 24'd0);
    wait_done(0, 200, "post");
    check_eq("post sck rises",  32'(rise_cnt[0] - rb),     32'd8);
    check_eq("post mosi bits",  32'(mosi_cap[0][7:0]),     32'h000000A5);
    check_eq("post cs low cycles", 32'(cs_low_cyc[0] - cb), 32'd17);
    drop0();

    // SCK_DIV=3 instance: read one byte 0x3C
    m_base[1] = rise_cnt[1];
    m_tx[1]   = 0;
    m_rx[1]   = 1;
    m_word[1] = 24'h00003C;
    rb = rise_cnt[1];
    bus1.out_bytes_count = 2'd0;
    bus1.in_bytes_count  = 2'd1;
    bus1.in_bytes        = 16'd0;
    bus1.start_trans     = 1'b1;
    wait_done(1, 400, "div");
    check_eq("div out_bytes",  bus1.out_bytes,          32'h0000003C);
    check_eq("div sck rises",  32'(rise_cnt[1] - rb),   32'd8);
    check_eq("div high min",   32'(hi_min[1]),          32'd3);
    check_eq("div high max",   32'(hi_max[1]),          32'd3);
    check_eq("div low min",    32'(lo_min[1]),          32'd3);
    check_eq("div low max",    32'(lo_max[1]),          32'd3);
    bus1.start_trans = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
